// File: rtl/button_events.sv
// button_events: turns a debounced, clk-synchronous button level into
// one-cycle event strobes (press, release, click, double-click, long-press,
// auto-repeat) and latches each event into a one-entry register that a CPU
// or interrupt stage drains through a valid/ready handshake.
module button_events #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int DCLICK_CYCLES = 25000000,
  parameter int CTR_W         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       press_o,
  output logic       release_o,
  output logic       click_o,
  output logic       dclick_o,
  output logic       long_o,
  output logic       repeat_o,
  output logic       held_o,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_ovf,
  input  logic       evt_ovf_clr,
  output logic [2:0] state_o
);

  // Handshake: an event transfers on every clk edge where evt_valid and
  // evt_ready are both high. While evt_valid is high and evt_ready is low,
  // evt_valid and evt_code hold; any new event in that time is dropped and
  // recorded in the sticky evt_ovf flag.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED   = 3'd1,
    S_WAIT2     = 3'd2,
    S_SECOND    = 3'd3,
    S_LONG_HELD = 3'd4
  } state_t;

  localparam logic [2:0] EVT_NONE    = 3'd0;
  localparam logic [2:0] EVT_PRESS   = 3'd1;
  localparam logic [2:0] EVT_RELEASE = 3'd2;
  localparam logic [2:0] EVT_CLICK   = 3'd3;
  localparam logic [2:0] EVT_DCLICK  = 3'd4;
  localparam logic [2:0] EVT_LONG    = 3'd5;
  localparam logic [2:0] EVT_REPEAT  = 3'd6;

  // "Expires at P" means the timer reads P-1 in the current cycle.
  localparam logic [CTR_W-1:0] LONG_LAST   = CTR_W'(LONG_CYCLES - 1);
  localparam logic [CTR_W-1:0] REPEAT_LAST = CTR_W'(REPEAT_CYCLES - 1);
  localparam logic [CTR_W-1:0] DCLICK_LAST = CTR_W'(DCLICK_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CTR_W-1:0] timer_q, timer_d;
  logic             btn_q;
  logic             rise, fall;

  logic press_q, press_d;
  logic release_q, release_d;
  logic click_q, click_d;
  logic dclick_q, dclick_d;
  logic long_q, long_d;
  logic repeat_q, repeat_d;
  logic held_q, held_d;
  logic [2:0] new_code;

  logic       evt_valid_q, evt_valid_d;
  logic [2:0] evt_code_q, evt_code_d;
  logic       evt_ovf_q, evt_ovf_d;

  assign rise = btn & ~btn_q;
  assign fall = ~btn & btn_q;

  // Next state, timer and event strobes; fall/rise beat a coinciding expiry.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
        end
      end
      S_PRESSED: begin
        if (fall) begin
          state_d   = S_WAIT2;
          release_d = 1'b1;
        end else if (timer_q == LONG_LAST) begin
          state_d = S_LONG_HELD;
          long_d  = 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (fall) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
        end else if (timer_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
        end
      end
      S_WAIT2: begin
        if (rise) begin
          state_d = S_SECOND;
          press_d = 1'b1;
        end else if (timer_q == DCLICK_LAST) begin
          state_d = S_IDLE;
          click_d = 1'b1;
        end
      end
      S_SECOND: begin
        if (fall) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
          dclick_d  = 1'b1;
        end else if (timer_q == LONG_LAST) begin
          // The first click of the pair is abandoned here.
          state_d = S_LONG_HELD;
          long_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A repeat tick restarts the period just like a state change does.
    if ((state_d != state_q) || repeat_d) begin
      timer_d = '0;
    end
  end

  // held_o follows the state being entered so it moves with press/release.
  always_comb begin
    held_d = (state_d == S_PRESSED) || (state_d == S_SECOND) ||
             (state_d == S_LONG_HELD);
  end

  // One code per cycle; dclick takes the slot when it coincides with release.
  always_comb begin
    new_code = EVT_NONE;
    if (dclick_d)       new_code = EVT_DCLICK;
    else if (press_d)   new_code = EVT_PRESS;
    else if (release_d) new_code = EVT_RELEASE;
    else if (click_d)   new_code = EVT_CLICK;
    else if (long_d)    new_code = EVT_LONG;
    else if (repeat_d)  new_code = EVT_REPEAT;
  end

  // Event slot: frees on handshake, reloads in the same cycle, drops when full.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_ovf_d   = evt_ovf_q;
    if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
    if (evt_ovf_clr) begin
      evt_ovf_d = 1'b0;
    end
    if (new_code != EVT_NONE) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = new_code;
      end else begin
        evt_ovf_d = 1'b1;
      end
    end
  end

  // FSM state, timer and input history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      btn_q   <= btn;
    end
  end

  // Registered strobes, held level and event register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      click_q     <= 1'b0;
      dclick_q    <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
      held_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= EVT_NONE;
      evt_ovf_q   <= 1'b0;
    end else begin
      press_q     <= press_d;
      release_q   <= release_d;
      click_q     <= click_d;
      dclick_q    <= dclick_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      held_q      <= held_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign click_o   = click_q;
  assign dclick_o  = dclick_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;
  assign held_o    = held_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_ovf   = evt_ovf_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with short timing parameters.
module tb_button_events;

  localparam int ST_IDLE   = 0;
  localparam int ST_WAIT2  = 2;
  localparam int ST_SECOND = 3;
  localparam int ST_LONG   = 4;

  // Clock / reset.
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       btn = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_ovf_clr = 1'b0;
  logic       press_o, release_o, click_o, dclick_o, long_o, repeat_o, held_o;
  logic       evt_valid, evt_ovf;
  logic [2:0] evt_code;
  logic [2:0] state_o;

  button_events #(
    .LONG_CYCLES(20), .REPEAT_CYCLES(5), .DCLICK_CYCLES(10), .CTR_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .press_o(press_o), .release_o(release_o), .click_o(click_o),
    .dclick_o(dclick_o), .long_o(long_o), .repeat_o(repeat_o),
    .held_o(held_o), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ready(evt_ready), .evt_ovf(evt_ovf), .evt_ovf_clr(evt_ovf_clr),
    .state_o(state_o)
  );

  // Scoreboard state.
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];
  int rd_idx = 0;
  int n_click = 0, n_dclick = 0, n_long = 0, n_repeat = 0;
  int b_click, b_dclick, b_long, b_repeat;

  // Monitor: strobe counts and events that complete a handshake.
  always @(negedge clk) begin
    if (click_o === 1'b1)  n_click++;
    if (dclick_o === 1'b1) n_dclick++;
    if (long_o === 1'b1)   n_long++;
    if (repeat_o === 1'b1) n_repeat++;
    if (evt_valid === 1'b1 && evt_ready === 1'b1) got_q.push_back(evt_code);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mark();
    b_click = n_click; b_dclick = n_dclick; b_long = n_long; b_repeat = n_repeat;
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, got_q.size() - rd_idx, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd_idx + i < got_q.size()) chk(tag, int'(got_q[rd_idx + i]), int'(exp_q[i]));
    end
    rd_idx = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    // Reset state.
    tick(3);
    chk("rst_press", press_o, 0);
    chk("rst_held", held_o, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_ovf", evt_ovf, 0);
    chk("rst_state", state_o, ST_IDLE);
    rst_n = 1'b1;
    tick(2);

    // 1: short click -> press, release, click 10 cycles after release.
    mark();
    btn = 1'b1; tick();
    chk("s1_press", press_o, 1);
    chk("s1_held", held_o, 1);
    chk("s1_code", evt_code, 1);
    tick(4);
    btn = 1'b0; tick();
    chk("s1_release", release_o, 1);
    chk("s1_held_lo", held_o, 0);
    chk("s1_state_w2", state_o, ST_WAIT2);
    tick(9);
    chk("s1_click_early", click_o, 0);
    tick();
    chk("s1_click", click_o, 1);
    tick(5);
    chk("s1_nolong", n_long - b_long, 0);
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    check_seq("s1_seq");

    // 2: double click.
    mark();
    btn = 1'b1; tick();
    tick(2);
    btn = 1'b0; tick();
    chk("s2_release1", release_o, 1);
    tick(3);
    btn = 1'b1; tick();
    chk("s2_press2", press_o, 1);
    chk("s2_state_sec", state_o, ST_SECOND);
    tick(2);
    btn = 1'b0; tick();
    chk("s2_release2", release_o, 1);
    chk("s2_dclick", dclick_o, 1);
    chk("s2_code", evt_code, 4);
    tick(15);
    chk("s2_noclick", n_click - b_click, 0);
    exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    exp_q.push_back(3'd1); exp_q.push_back(3'd4);
    check_seq("s2_seq");

    // 3: long press with two auto-repeat ticks.
    mark();
    btn = 1'b1; tick();
    chk("s3_press", press_o, 1);
    tick(19);
    chk("s3_long_early", long_o, 0);
    tick();
    chk("s3_long", long_o, 1);
    chk("s3_state_long", state_o, ST_LONG);
    tick(4);
    chk("s3_rep_early", repeat_o, 0);
    tick();
    chk("s3_rep1", repeat_o, 1);
    tick(5);
    chk("s3_rep2", repeat_o, 1);
    chk("s3_held", held_o, 1);
    tick();
    btn = 1'b0; tick();
    chk("s3_release", release_o, 1);
    chk("s3_held_lo", held_o, 0);
    tick(12);
    chk("s3_nrep", n_repeat - b_repeat, 2);
    chk("s3_noclick", n_click - b_click, 0);
    exp_q.push_back(3'd1); exp_q.push_back(3'd5); exp_q.push_back(3'd6);
    exp_q.push_back(3'd6); exp_q.push_back(3'd2);
    check_seq("s3_seq");

    // 4: consumer stalled -> hold, drop, overflow, clear, drain.
    evt_ready = 1'b0;
    btn = 1'b1; tick();
    chk("s4_valid", evt_valid, 1);
    tick(2);
    btn = 1'b0; tick();
    chk("s4_release", release_o, 1);
    chk("s4_code_hold", evt_code, 1);
    chk("s4_ovf", evt_ovf, 1);
    tick(10);
    chk("s4_click", click_o, 1);
    chk("s4_code_hold2", evt_code, 1);
    evt_ovf_clr = 1'b1; tick();
    evt_ovf_clr = 1'b0;
    chk("s4_ovf_clr", evt_ovf, 0);
    chk("s4_valid_hold", evt_valid, 1);
    evt_ready = 1'b1; tick();
    chk("s4_drained", evt_valid, 0);
    exp_q.push_back(3'd1);
    check_seq("s4_seq");

    // 5: reset during PRESSED, then press again with btn still high; the
    //    fall lands on the long-expiry cycle (release wins, no long).
    btn = 1'b1; tick();
    tick(12);
    rst_n = 1'b0; #1;
    chk("s5_rst_held", held_o, 0);
    chk("s5_rst_valid", evt_valid, 0);
    chk("s5_rst_state", state_o, ST_IDLE);
    tick(2);
    rst_n = 1'b1;
    mark();
    tick();
    chk("s5_press", press_o, 1);
    tick(19);
    chk("s5_nolong", n_long - b_long, 0);
    btn = 1'b0; tick();
    chk("s5_release_bnd", release_o, 1);
    chk("s5_long_bnd", long_o, 0);
    tick(12);
    chk("s5_nolong_end", n_long - b_long, 0);
    exp_q.push_back(3'd1); exp_q.push_back(3'd1);
    exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    check_seq("s5_seq");

    // 6: second press lands on the double-click expiry cycle (press wins).
    mark();
    btn = 1'b1; tick();
    tick(2);
    btn = 1'b0; tick();
    tick(9);
    btn = 1'b1; tick();
    chk("s6_press_bnd", press_o, 1);
    chk("s6_click_bnd", click_o, 0);
    chk("s6_held", held_o, 1);
    tick(2);
    btn = 1'b0; tick();
    chk("s6_dclick", dclick_o, 1);
    tick(12);
    chk("s6_noclick", n_click - b_click, 0);
    exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    exp_q.push_back(3'd1); exp_q.push_back(3'd4);
    check_seq("s6_seq");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Consumes the debounced, already-synchronised level from the button conditioner and converts it into discrete button events: press, release, click, double-click, long-press and auto-repeat.
- Each event is a one-cycle strobe. Each event is also latched into a one-entry event register with a valid/ready handshake, for a CPU-facing register or interrupt stage.
- Sits directly downstream of the conditioner, in the same clock domain.

Parameters:
- LONG_CYCLES, 50000000: hold duration, in clk cycles, that qualifies a long press.
- REPEAT_CYCLES, 10000000: auto-repeat period, in clk cycles, while long-held.
- DCLICK_CYCLES, 25000000: window, in clk cycles, after a short-press release in which a second press makes a double-click.
- CTR_W, 26: timer width. Must satisfy max(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES) <= 2**CTR_W. All three parameters must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn  in  1  debounced button level, already synchronous to clk.
- press_o  out  1  one-cycle strobe on each press.
- release_o  out  1  one-cycle strobe on each release.
- click_o  out  1  one-cycle strobe: single short click confirmed.
- dclick_o  out  1  one-cycle strobe: double-click.
- long_o  out  1  one-cycle strobe: long-press threshold reached.
- repeat_o  out  1  one-cycle strobe: auto-repeat tick.
- held_o  out  1  level, high while in PRESSED, SECOND or LONG_HELD.
- evt_valid  out  1  event register holds an unconsumed event.
- evt_code  out  3  code of that event: 1=press, 2=release, 3=click, 4=dclick, 5=long, 6=repeat.
- evt_ready  in  1  consumer accepts the event.
- evt_ovf  out  1  sticky flag: an event was dropped.
- evt_ovf_clr  in  1  clears evt_ovf.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; timer 0; btn_q 0.
  - Asynchronous assert, synchronous release.
  - Reset mid-sequence discards the sequence and any pending event. No strobes are emitted for it.
- Edge detection: rise = btn & ~btn_q; fall = ~btn & btn_q. btn_q is registered btn.
- Latency: all outputs are registered. A strobe is high in the cycle after the clk edge that sampled its cause.
  - Example: btn is first sampled high at edge N; press_o is high for exactly the cycle following edge N.
- The timer resets to 0 on every state transition and increments by 1 each cycle otherwise. "Expires at P" means timer == P-1.
- FSM:
  - IDLE: rise -> PRESSED, press.
  - PRESSED:
    - fall -> WAIT2, release.
    - Timer expires at LONG_CYCLES while btn high -> LONG_HELD, long.
    - If fall and expiry coincide, fall wins.
  - LONG_HELD:
    - Timer expires at REPEAT_CYCLES -> repeat; timer restarts; stay.
    - fall -> IDLE, release; no click.
    - If fall and expiry coincide, fall wins.
  - WAIT2:
    - rise -> SECOND, press.
    - Timer expires at DCLICK_CYCLES -> IDLE, click.
    - If rise and expiry coincide, rise wins.
  - SECOND:
    - fall -> IDLE, release plus dclick in the same cycle.
    - Timer expires at LONG_CYCLES -> LONG_HELD, long; the pending first click is discarded.
- Event register:
  - Each cycle carries at most one event. When release and dclick coincide, the register captures dclick; both strobes still fire.
  - Load rule, evaluated per cycle:
    - If evt_valid && evt_ready: the slot frees this cycle; a new event in the same cycle loads (back-to-back, no bubble).
    - Else if !evt_valid: a new event loads.
    - Else: the new event is dropped and evt_ovf is set.
  - evt_valid and evt_code hold stable while !evt_ready.
  - evt_ovf_clr clears evt_ovf. If a drop coincides with evt_ovf_clr, set wins.
- held_o changes in the same cycle as the corresponding press_o/release_o.

Test Plan:
All scenarios use LONG_CYCLES=20, REPEAT_CYCLES=5, DCLICK_CYCLES=10, CTR_W=8, with evt_ready held 1 unless stated.
1. btn high 5 cycles, then low 15 cycles -> press_o, release_o, then click_o 10 cycles after the release strobe. Event sequence 1, 2, 3. No long_o.
2. btn high 3, low 4, high 3, low -> press, release, press, then release_o and dclick_o in the same cycle. Event sequence 1, 2, 1, 4. No click_o.
3. btn high 32 cycles -> long_o 20 cycles after press_o; repeat_o 5, 10 cycles later (two pulses); release_o on fall. No click_o. held_o high throughout.
4. evt_ready=0, then short click -> evt_code=1 held stable; release dropped with evt_ovf=1; click also dropped. Pulse evt_ovf_clr -> evt_ovf=0. Raise evt_ready -> evt_valid falls after one handshake.
5. Assert rst_n=0 during PRESSED at timer=12 -> all outputs 0 immediately. After release with btn still high, press_o fires one cycle later, and no long_o within 19 cycles.
6. Boundary: btn falls exactly on the cycle of LONG expiry -> release_o, no long_o. In WAIT2, rise on the cycle of DCLICK expiry -> press_o, no click_o.
